// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// mode-qualified rise/fall pulses, sticky flags and saturating counters.
module multi_edge_detect #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         a_in,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         re_pulse,
    output logic [N_CH-1:0]         fe_pulse,
    output logic [N_CH-1:0]         ev_sticky,
    output logic [N_CH*CNT_W-1:0]   ev_count,
    output logic                    any_event
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0]    F_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;

    logic [N_CH-1:0] pend_r_v;
    logic [N_CH-1:0] pend_f_v;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sr;
        logic                   sync;
        logic                   filt;
        logic [FW-1:0]          fcnt;
        logic                   flip;
        logic                   pend_r;
        logic                   pend_f;
        logic                   ev;
        logic                   re_r;
        logic                   fe_r;
        logic                   st_r;
        logic [CNT_W-1:0]       cnt_r;

        assign sync = sr[SYNC_STAGES-1];
        assign flip = (sync != filt) && (fcnt == F_LAST);
        assign ev   = pend_r | pend_f;

        // Synchroniser and glitch filter; tracking ignores mode.
        always_ff @(posedge clk) begin
            if (reset) begin
                sr   <= '0;
                filt <= 1'b0;
                fcnt <= '0;
            end else begin
                sr <= {sr[SYNC_STAGES-2:0], a_in[gi]};
                if (sync == filt) begin
                    fcnt <= '0;
                end else if (flip) begin
                    filt <= ~filt;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end

        // Mode is sampled on the flip edge; the pulse registers one edge later.
        always_ff @(posedge clk) begin
            if (reset) begin
                pend_r <= 1'b0;
                pend_f <= 1'b0;
                re_r   <= 1'b0;
                fe_r   <= 1'b0;
            end else begin
                pend_r <= flip & ~filt & mode[2*gi];
                pend_f <= flip & filt & mode[2*gi+1];
                re_r   <= pend_r;
                fe_r   <= pend_f;
            end
        end

        // An event on the same edge as clr wins over the clear.
        always_ff @(posedge clk) begin
            if (reset) begin
                st_r  <= 1'b0;
                cnt_r <= '0;
            end else begin
                if (ev) begin
                    st_r <= 1'b1;
                end else if (clr[gi]) begin
                    st_r <= 1'b0;
                end
                if (clr[gi]) begin
                    cnt_r <= ev ? CNT_W'(1) : '0;
                end else if (ev && (cnt_r != C_MAX)) begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end

        assign pend_r_v[gi]                 = pend_r;
        assign pend_f_v[gi]                 = pend_f;
        assign re_pulse[gi]                 = re_r;
        assign fe_pulse[gi]                 = fe_r;
        assign ev_sticky[gi]                = st_r;
        assign ev_count[CNT_W*gi +: CNT_W]  = cnt_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |(pend_r_v | pend_f_v);
        end
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios plus random stimulus
// compared every cycle against a behavioural reference model.
module tb_multi_edge_detect;

    localparam int N    = 4;
    localparam int S    = 2;
    localparam int F    = 3;
    localparam int W    = 8;
    localparam int CMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   a_in;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clr;
    logic [N-1:0]   re_pulse;
    logic [N-1:0]   fe_pulse;
    logic [N-1:0]   ev_sticky;
    logic [N*W-1:0] ev_count;
    logic           any_event;

    multi_edge_detect #(
        .N_CH(N), .SYNC_STAGES(S), .FILT_CYCLES(F), .CNT_W(W)
    ) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .mode(mode), .clr(clr),
        .re_pulse(re_pulse), .fe_pulse(fe_pulse), .ev_sticky(ev_sticky),
        .ev_count(ev_count), .any_event(any_event)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: delay line of samples, run length of disagreement,
    // events scheduled one edge after the filtered level is accepted.
    bit m_q[N][$];
    bit m_filt[N];
    int m_run[N];
    bit m_pr[N];
    bit m_pf[N];
    bit m_re[N];
    bit m_fe[N];
    bit m_st[N];
    int m_cnt[N];
    bit m_any;

    task automatic model_edge();
        bit any;
        bit ev;
        bit sync;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_q[i] = {};
                for (int k = 0; k < S; k++) m_q[i].push_back(1'b0);
                m_filt[i] = 0; m_run[i] = 0;
                m_pr[i] = 0; m_pf[i] = 0;
                m_re[i] = 0; m_fe[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
            end else begin
                ev = m_pr[i] | m_pf[i];
                m_re[i] = m_pr[i];
                m_fe[i] = m_pf[i];
                any |= ev;
                if (ev) m_st[i] = 1;
                else if (clr[i]) m_st[i] = 0;
                if (clr[i]) m_cnt[i] = ev ? 1 : 0;
                else if (ev && m_cnt[i] < CMAX) m_cnt[i]++;
                sync = m_q[i][0];
                m_pr[i] = 0;
                m_pf[i] = 0;
                if (sync != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == F) begin
                        m_filt[i] = !m_filt[i];
                        m_run[i] = 0;
                        m_pr[i] = m_filt[i] & mode[2*i];
                        m_pf[i] = !m_filt[i] & mode[2*i+1];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_q[i].push_back(a_in[i]);
                void'(m_q[i].pop_front());
            end
        end
        m_any = reset ? 1'b0 : any;
    endtask

    task automatic compare();
        logic [N-1:0]   er, ef, es;
        logic [N*W-1:0] ec;
        for (int i = 0; i < N; i++) begin
            er[i] = m_re[i];
            ef[i] = m_fe[i];
            es[i] = m_st[i];
            ec[i*W +: W] = W'(m_cnt[i]);
        end
        check("re_pulse", re_pulse, er);
        check("fe_pulse", fe_pulse, ef);
        check("ev_sticky", ev_sticky, es);
        check("ev_count", ev_count, ec);
        check("any_event", any_event, m_any);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(2);
    endtask

    int hold[N];
    bit seen;

    initial begin
        reset = 1'b1;
        a_in  = '0;
        mode  = '0;
        clr   = '0;
        ticks(2);
        check("rst_count", ev_count, 0);
        check("rst_sticky", ev_sticky, 0);
        reset = 1'b0;
        ticks(2);

        // Rise latency on ch0
        mode = 8'b0000_0001;
        a_in[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("lat_re0", re_pulse[0], (e == 5));
            check("lat_any", any_event, (e == 5));
        end
        check("lat_fe", fe_pulse, 0);
        check("lat_cnt", ev_count[W-1:0], 1);
        check("lat_st", ev_sticky[0], 1);

        // Glitch rejection, then accepted short pulse
        a_in[0] = 1'b0;
        ticks(8);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        mode = 8'b0000_0011;
        a_in[0] = 1'b1;
        ticks(2);
        a_in[0] = 1'b0;
        ticks(10);
        check("glitch_cnt", ev_count[W-1:0], 0);
        a_in[0] = 1'b1;
        ticks(3);
        a_in[0] = 1'b0;
        ticks(12);
        check("short_cnt", ev_count[W-1:0], 2);

        // Mode off during rise, enabled while high
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        mode = 8'b0000_0000;
        a_in[0] = 1'b1;
        ticks(8);
        mode = 8'b0000_0001;
        ticks(3);
        a_in[0] = 1'b0;
        ticks(8);
        check("modeoff_cnt", ev_count[W-1:0], 0);
        a_in[0] = 1'b1;
        ticks(8);
        check("modeon_cnt", ev_count[W-1:0], 1);

        // Saturation and clr/event collision
        do_reset();
        mode = 8'b0000_0011;
        for (int k = 0; k < 1300; k++) begin
            if (k % 4 == 0) a_in[0] = ~a_in[0];
            tick();
        end
        check("sat_cnt", ev_count[W-1:0], 255);
        ticks(10);
        a_in[0] = ~a_in[0];
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_pr[0] | m_pf[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("pend_seen", seen, 1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("clr_ev_cnt", ev_count[W-1:0], 1);
        check("clr_ev_st", ev_sticky[0], 1);
        ticks(10);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check("clr_cnt", ev_count[W-1:0], 0);
        check("clr_st", ev_sticky[0], 0);

        // Reset mid-transition with input held high
        do_reset();
        mode = 8'b0000_0001;
        a_in = '0;
        ticks(10);
        a_in[0] = 1'b1;
        ticks(4);
        reset = 1'b1;
        tick();
        check("midrst_out", {re_pulse, fe_pulse, ev_sticky, any_event}, 0);
        check("midrst_cnt", ev_count, 0);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("post_rst_re0", re_pulse[0], (e == 5));
        end

        // Simultaneous events on ch1 and ch2
        do_reset();
        mode = '0;
        a_in = 4'b0100;
        ticks(10);
        mode = 8'b0010_0100;
        a_in = 4'b0010;
        for (int e = 0; e < 8; e++) begin
            tick();
            check("multi_re", re_pulse, (e == 5) ? 4'b0010 : 4'b0000);
            check("multi_fe", fe_pulse, (e == 5) ? 4'b0100 : 4'b0000);
            check("multi_any", any_event, (e == 5));
        end

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 7);
        mode = 8'($urandom);
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    a_in[i] = ~a_in[i];
                    hold[i] = $urandom_range(1, 7);
                end else begin
                    hold[i]--;
                end
                if ($urandom_range(0, 29) == 0) mode[2*i +: 2] = 2'($urandom);
                clr[i] = ($urandom_range(0, 19) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        clr = '0;
        ticks(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_edge_detect.md
Name: multi_edge_detect

Overview:
Parametrised multi-channel edge detector, the successor to the single-bit rise/fall detector. Each channel synchronises an asynchronous input, applies a glitch filter, and emits per-mode rise/fall pulses. Each channel also keeps a sticky event flag and a saturating event counter. It sits between raw external/status pins and the control/status register block, which polls and clears the sticky flags and counters.

Parameters:
N_CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in each input synchroniser chain (>=2)
FILT_CYCLES, 3, consecutive stable synchronised cycles required to accept a level change (>=1)
CNT_W, 8, width of each per-channel event counter (>=1)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
a_in  input  N_CH  raw per-channel inputs, asynchronous to clk
mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  input  N_CH  per-channel clear of sticky flag and counter, one-cycle strobe
re_pulse  output  N_CH  registered one-cycle rising-edge pulse, mode-qualified
fe_pulse  output  N_CH  registered one-cycle falling-edge pulse, mode-qualified
ev_sticky  output  N_CH  set by any qualified event; held until clr
ev_count  output  N_CH*CNT_W  per-channel qualified-event count, bits [CNT_W*(i+1)-1:CNT_W*i]
any_event  output  1  registered OR of all re_pulse/fe_pulse bits

Behaviour:
- Reset (clk edge with reset=1): synchroniser flops, filtered level, filter counter, re_pulse, fe_pulse, ev_sticky, ev_count and any_event all go to 0. Reset overrides every other input, including clr.
- Synchroniser: SYNC_STAGES-flop shift register per channel. Call the last stage sync.
- Filter (per channel): state is the filtered level filt and a counter fcnt.
  - sync==filt: fcnt<=0.
  - sync!=filt and fcnt==FILT_CYCLES-1: filt flips, fcnt<=0.
  - Otherwise fcnt increments.
  - A sync excursion shorter than FILT_CYCLES cycles is discarded.
  - Filter tracking is independent of mode.
- Latency: a_in changes before edge 0 and is held. sync updates at edge SYNC_STAGES-1, filt flips at edge SYNC_STAGES+FILT_CYCLES-1, and the pulse is high for exactly one cycle after edge SYNC_STAGES+FILT_CYCLES. With defaults, the pulse is high between edges 5 and 6.
- Pulse qualification: re_pulse[i] requires mode bit 2i=1; fe_pulse[i] requires mode bit 2i+1=1. mode is sampled on the same edge as the filt flip. A mode change never generates or replays a pulse.
- Sticky: ev_sticky[i] is set on the edge where a qualified pulse registers and cleared by clr[i]. If clr and an event arrive on the same edge, set wins (ev_sticky=1).
- Counter: increments by 1 per qualified pulse and saturates at 2^CNT_W-1 (no wrap). clr resets it to 0. If clr and an event arrive on the same edge, ev_count=1.
- Sticky flag and counter update on the same edge the pulse registers, so they are visible in the same cycle as the pulse.
- any_event is registered alongside the pulses and is high in the same cycle as them.
- Channels are fully independent; simultaneous events on several channels are all reported.
- Reset mid-operation:
  - A partially filtered transition is lost.
  - After release, filt restarts at 0, so an input held high through reset produces one rising event SYNC_STAGES+FILT_CYCLES edges after release (mode permitting).
  - An input held low produces none.

Test Plan:
- Defaults, mode[1:0]=01, a_in[0] 0->1 held -> re_pulse[0] high only in cycle after edge 5; ev_sticky[0]=1, ev_count[0]=1, any_event high same cycle; fe_pulse stays 0.
- a_in[0] high for 2 sync cycles then low (mode 11) -> no pulses, ev_count[0] remains 0; a 3-cycle high is accepted -> re_pulse then fe_pulse, count=2.
- mode[1:0]=00 while a_in[0] rises; switch to 01 while high -> no pulse; subsequent fall produces none; next rise -> one re_pulse, count=1.
- CNT_W=8, 260 qualified events -> ev_count[0]=255; assert clr[0] on the same edge as an event -> ev_count[0]=1, ev_sticky[0]=1; clr alone -> 0 and 0.
- Reset asserted with fcnt=2 mid-transition, a_in held high -> all outputs 0 next cycle; after release, one re_pulse at edge 5 post-release.
- ch1 rise and ch2 fall on the same cycle (modes 01 and 10) -> re_pulse[1] and fe_pulse[2] in the same cycle, single-cycle any_event, ch0/ch3 unaffected.
